sawtooth_freq_detector: RTL and testbench
=========================================

// Module: sawtooth_freq_detector
// PURPOSE
// Receive-side counterpart of the sawtooth generator: takes a 16-bit signed sawtooth sample stream.
// Detects ramp wrap-arounds, measures the period in accepted samples, and recovers the 32-bit phase_step
// that produced it (phase_step = floor(2^32 / period)). Used in the signal-test path to close the loop
// on generator settings.
// PARAMETERS
// PERIOD_W     20       width of period counter; max measurable period 2^PERIOD_W-1 samples
// WRAP_THRESH  32768    a wrap is a sample-to-sample drop strictly greater than this value
// PORTS
// clk            in   1          system clock
// rst            in   1          synchronous reset, active-high
// sample_valid   in   1          sample_in is accepted on this cycle
// sample_in      in   16         signed two's-complement sawtooth sample
// phase_step_out out  32         recovered phase step, held until next result
// period_out     out  PERIOD_W   measured period in samples, held until next result
// result_valid   out  1          one-cycle pulse: phase_step_out/period_out updated this cycle
// locked         out  1          high after first result; cleared on timeout or reset
// overrun        out  1          sticky: a wrap arrived while the divider was busy; cleared by rst only
// BEHAVIOUR
// - Reset: all outputs 0, prev sample 0, counter 0, FSM IDLE, divider idle, first-sample flag cleared.
// - Wrap detect: on accepted sample, (17-bit signed) prev - sample_in > WRAP_THRESH. Never on the first sample after reset.
// - Counter: on a wrap sample, load 1; on other accepted samples, +1, saturating at 2^PERIOD_W-1.
// - FSM IDLE: the first wrap goes to MEASURE. No result is produced.
// - FSM MEASURE: on a wrap with counter >= 2, launch the divider with 2^32 / counter and go to DIVIDE.
//   A wrap with counter < 2 is ignored; the counter reloads.
// - FSM DIVIDE: a 33-iteration restoring divide. The wrap sample is accepted at cycle T, the divider
//   loads at T+1, and result_valid pulses at T+34 together with the updated outputs. Then return to MEASURE.
// - Wrap during DIVIDE: that period is discarded, overrun is set, the counter reloads to 1, and the
//   running divide completes normally.
// - Timeout: when the counter saturates, clear locked and go to IDLE; any in-flight divide result is
//   still delivered.
// - Quotient is 33 bits; min period 2 gives 2^31. Saturate to 32'hFFFF_FFFF (unreachable for period >= 2).
// - sample_valid low: no state advances except the divider.
// - Simultaneous saturation and wrap: the wrap wins; saturation timeout does not fire.
// CONFIGURATION
// - SAWTOOTH_DET_AVG4_EN defined: the divider launches every 4th valid period. It divides 2^34 by the sum
//   of 4 consecutive periods (sum width PERIOD_W+2). period_out = sum>>2.
//   Latency after the 4th wrap: 36 cycles (35 iterations). Discarded or short periods restart the group of 4.
// - Not defined: single-period measurement as above.
// STRUCTURE
// - Package sawtooth_det_pkg: state_t enum {IDLE, MEASURE, DIVIDE}; DIV_ITERS (33, or 35 with AVG4);
//   PHASE_W = 32.
// - Sub-module sawtooth_det_div: sequential restoring divider with start/busy/done,
//   parameterised dividend and divisor widths.
// - Top: input register/wrap compare, counter, FSM, output registers.
// TESTING
// 1 Generator phase_step 32'h0100_0000, sample_valid=1 -> period_out=256, phase_step_out=32'h0100_0000, locked=1.
// 2 Synthetic ramp with period 1000 -> phase_step_out=32'd4294967. result_valid exactly 34 clk after the wrap sample.
// 3 Ramp with a -20000 glitch mid-ramp -> no false wrap; period unchanged.
// 4 Constant input after lock -> locked drops when the counter hits 2^20-1; FSM returns to IDLE.
// 5 Period 10 (< divide latency) -> overrun=1; results only for periods whose wrap fell outside DIVIDE.
// 6 rst asserted at T+15 mid-divide -> no result_valid, all outputs 0. Relock on subsequent ramps.

Source files
------------

// File: rtl/sawtooth_det_pkg.sv
// Shared types and constants for the sawtooth frequency detector.
// SAWTOOTH_DET_AVG4_EN selects four-period averaging (wider divide).
package sawtooth_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  localparam int unsigned PHASE_W = 32;

`ifdef SAWTOOTH_DET_AVG4_EN
  localparam int unsigned DIV_ITERS = 35;
  localparam int unsigned SUM_EXTRA = 2;
`else
  localparam int unsigned DIV_ITERS = 33;
  localparam int unsigned SUM_EXTRA = 0;
`endif

  // Clamp the wide quotient to the phase-step width.
  function automatic logic [PHASE_W-1:0] sat_phase(input logic [DIV_ITERS-1:0] q);
    logic [PHASE_W-1:0] r;
    r = q[PHASE_W-1:0];
    if (|q[DIV_ITERS-1:PHASE_W]) r = '1;
    return r;
  endfunction

endpackage

// File: rtl/sawtooth_det_div.sv
// Sequential restoring divider: one quotient bit per cycle, DVD_W cycles per divide.
// done_c_o / quot_c_o are combinational and valid on the final iteration cycle.
module sawtooth_det_div #(
  parameter int unsigned DVD_W = 33,
  parameter int unsigned DVS_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_c_o,
  output logic [DVD_W-1:0] quot_c_o
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] dq_q;

  logic [DVS_W:0]   rem_sh_c;
  logic             ge_c;
  logic [DVS_W-1:0] rem_nx_c;
  logic [DVD_W-1:0] dq_nx_c;

  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh_c = {rem_q, dq_q[DVD_W-1]};
    ge_c     = (rem_sh_c >= {1'b0, dvs_q});
    rem_nx_c = rem_sh_c[DVS_W-1:0];
    if (ge_c) rem_nx_c = DVS_W'(rem_sh_c - {1'b0, dvs_q});
    dq_nx_c  = {dq_q[DVD_W-2:0], ge_c};
  end

  assign busy_o   = busy_q;
  assign done_c_o = busy_q && (cnt_q == CNT_W'(1));
  assign quot_c_o = dq_nx_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      dq_q   <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(DVD_W);
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      dq_q   <= dividend_i;
    end else if (busy_q) begin
      busy_q <= (cnt_q != CNT_W'(1));
      cnt_q  <= cnt_q - CNT_W'(1);
      rem_q  <= rem_nx_c;
      dq_q   <= dq_nx_c;
    end
  end

endmodule

// File: rtl/sawtooth_freq_detector.sv
// Recovers a sawtooth generator's phase step from its sample stream by timing ramp wraps.
// Optional macro SAWTOOTH_DET_AVG4_EN averages four consecutive periods per result.
module sawtooth_freq_detector
  import sawtooth_det_pkg::*;
#(
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned WRAP_THRESH = 32768
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [15:0]         sample_in,
  output logic [PHASE_W-1:0]  phase_step_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                result_valid,
  output logic                locked,
  output logic                overrun
);

  localparam int unsigned          DVS_W    = PERIOD_W + SUM_EXTRA;
  localparam logic [PERIOD_W-1:0]  CNT_MAX  = '1;
  localparam logic [DIV_ITERS-1:0] DIVIDEND = {1'b1, {(DIV_ITERS-1){1'b0}}};

  state_t state_q, state_d;

  logic [15:0]         prev_q;
  logic                seen_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [DVS_W-1:0]    dvs_q, dvs_d;
  logic [PERIOD_W-1:0] pend_q, pend_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                rv_q, rv_d;
  logic                locked_q, locked_d;
  logic                overrun_q, overrun_d;
`ifdef SAWTOOTH_DET_AVG4_EN
  logic [1:0]          grp_q, grp_d;
  logic [DVS_W-1:0]    sum_q, sum_d;
  logic [DVS_W-1:0]    sum_tot_c;
`endif

  logic signed [16:0]   diff_c;
  logic                 wrap_c;
  logic                 sat_c;
  logic                 div_busy;
  logic                 div_done_c;
  logic [DIV_ITERS-1:0] div_quot_c;

  // A wrap is a large downward step; the very first sample has no predecessor.
  assign diff_c = $signed({prev_q[15], prev_q}) - $signed({sample_in[15], sample_in});
  assign wrap_c = sample_valid && seen_q && (diff_c > $signed(17'(WRAP_THRESH)));

  // Period counter: a wrap sample starts the next period as sample 1.
  always_comb begin
    cnt_d = cnt_q;
    sat_c = 1'b0;
    if (sample_valid) begin
      if (wrap_c) begin
        cnt_d = PERIOD_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
      sat_c = !wrap_c && (cnt_d == CNT_MAX);
    end
  end

`ifdef SAWTOOTH_DET_AVG4_EN
  assign sum_tot_c = sum_q + DVS_W'(cnt_q);
`endif

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    dvs_d     = dvs_q;
    pend_d    = pend_q;
    phase_d   = phase_q;
    period_d  = period_q;
    rv_d      = 1'b0;
    locked_d  = locked_q;
    overrun_d = overrun_q;
`ifdef SAWTOOTH_DET_AVG4_EN
    grp_d     = grp_q;
    sum_d     = sum_q;
`endif

    // In-flight results are delivered whatever state the FSM has moved to.
    if (div_done_c) begin
      rv_d     = 1'b1;
      phase_d  = sat_phase(div_quot_c);
      period_d = pend_q;
      locked_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
`ifdef SAWTOOTH_DET_AVG4_EN
        grp_d = '0;
        sum_d = '0;
`endif
        if (wrap_c) state_d = MEASURE;
      end
      MEASURE: begin
        if (wrap_c && (cnt_q >= PERIOD_W'(2)) && !div_busy) begin
`ifdef SAWTOOTH_DET_AVG4_EN
          if (grp_q == 2'd3) begin
            start_d = 1'b1;
            dvs_d   = sum_tot_c;
            pend_d  = PERIOD_W'(sum_tot_c >> 2);
            grp_d   = '0;
            sum_d   = '0;
            state_d = DIVIDE;
          end else begin
            grp_d = grp_q + 2'd1;
            sum_d = sum_tot_c;
          end
`else
          start_d = 1'b1;
          dvs_d   = DVS_W'(cnt_q);
          pend_d  = cnt_q;
          state_d = DIVIDE;
`endif
        end
`ifdef SAWTOOTH_DET_AVG4_EN
        else if (wrap_c) begin
          grp_d = '0;
          sum_d = '0;
        end
`endif
      end
      DIVIDE: begin
        if (wrap_c) begin
          overrun_d = 1'b1;
`ifdef SAWTOOTH_DET_AVG4_EN
          grp_d = '0;
          sum_d = '0;
`endif
        end
        if (div_done_c) state_d = MEASURE;
      end
      default: state_d = IDLE;
    endcase

    // Saturated counter means the ramp stopped: drop lock and re-arm.
    if (sat_c) begin
      locked_d = 1'b0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      seen_q    <= 1'b0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      dvs_q     <= '0;
      pend_q    <= '0;
      phase_q   <= '0;
      period_q  <= '0;
      rv_q      <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SAWTOOTH_DET_AVG4_EN
      grp_q     <= '0;
      sum_q     <= '0;
`endif
    end else begin
      if (sample_valid) begin
        prev_q <= sample_in;
        seen_q <= 1'b1;
      end
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      dvs_q     <= dvs_d;
      pend_q    <= pend_d;
      phase_q   <= phase_d;
      period_q  <= period_d;
      rv_q      <= rv_d;
      locked_q  <= locked_d;
      overrun_q <= overrun_d;
`ifdef SAWTOOTH_DET_AVG4_EN
      grp_q     <= grp_d;
      sum_q     <= sum_d;
`endif
    end
  end

  sawtooth_det_div #(
    .DVD_W (DIV_ITERS),
    .DVS_W (DVS_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_q),
    .dividend_i (DIVIDEND),
    .divisor_i  (dvs_q),
    .busy_o     (div_busy),
    .done_c_o   (div_done_c),
    .quot_c_o   (div_quot_c)
  );

  assign phase_step_out = phase_q;
  assign period_out     = period_q;
  assign result_valid   = rv_q;
  assign locked         = locked_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_sawtooth_freq_detector.sv
// Randomised and directed bench for sawtooth_freq_detector against a sample-level reference model.
`timescale 1ns/1ps
module tb_sawtooth_freq_detector;

  localparam int unsigned PW     = 12;
  localparam int          MAXC   = (1 << PW) - 1;
  localparam int          THRESH = 32768;
  localparam int          LAT    = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [15:0]   sample_in = '0;
  logic [31:0]   phase_step_out;
  logic [PW-1:0] period_out;
  logic          result_valid;
  logic          locked;
  logic          overrun;

  always #5 clk = ~clk;

  sawtooth_freq_detector #(.PERIOD_W(PW), .WRAP_THRESH(THRESH)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid   (sample_valid),
    .sample_in      (sample_in),
    .phase_step_out (phase_step_out),
    .period_out     (period_out),
    .result_valid   (result_valid),
    .locked         (locked),
    .overrun        (overrun)
  );

  typedef struct {
    longint      due;
    logic [31:0] phase;
    int          period;
  } res_t;

  res_t        pend[$];
  longint      cyc = 0;
  bit          started = 0;
  int          prev_s;
  bit          have_prev, armed;
  int          run_len;
  longint      busy_until;
  bit          m_rv, m_locked, m_overrun;
  logic [31:0] m_phase;
  int          m_period;
  int          n_chk = 0;
  int          n_pass = 0;
  longint      last_rv_edge = -1;

  function automatic logic [31:0] exp_phase(input int p);
    longint q;
    q = 64'h1_0000_0000 / longint'(p);
    if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: works on whole samples and absolute cycle numbers.
  always @(posedge clk) begin
    int  s;
    bit  wrap;
    res_t r;
    cyc++;
    started = 1;
    m_rv = 0;
    if (rst) begin
      pend.delete();
      have_prev = 0; armed = 0; run_len = 0; busy_until = cyc;
      m_locked = 0; m_overrun = 0; m_phase = 0; m_period = 0; prev_s = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        m_rv = 1; m_phase = r.phase; m_period = r.period; m_locked = 1;
      end
      if (sample_valid) begin
        s = int'($signed(sample_in));
        wrap = have_prev && ((prev_s - s) > THRESH);
        have_prev = 1;
        prev_s = s;
        if (wrap) begin
          if (!armed) armed = 1;
          else if (cyc <= busy_until) m_overrun = 1;
          else if (run_len >= 2) begin
            r.due = cyc + LAT; r.phase = exp_phase(run_len); r.period = run_len;
            pend.push_back(r);
            busy_until = cyc + LAT;
          end
          run_len = 1;
        end else begin
          if (run_len < MAXC) run_len++;
          if (run_len == MAXC) begin armed = 0; m_locked = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("result_valid", result_valid, m_rv);
      check("locked", locked, m_locked);
      check("overrun", overrun, m_overrun);
      check("phase_step_out", phase_step_out, m_phase);
      check("period_out", period_out, m_period);
    end
    if (result_valid === 1'b1) last_rv_edge = cyc;
  end

  task automatic drive(input logic v, input logic [15:0] s);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; sample_valid = 0; sample_in = 0;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  task automatic ramp(input int period, input int step, input int n, input int glitch_at);
    int v;
    for (int i = 0; i < n; i++) begin
      v = -32768 + (i % period) * step;
      if ((i % period) == glitch_at) v = v - 20000;
      drive(1'b1, 16'(v));
    end
  endtask

  initial begin
    logic [31:0] ph;
    logic [31:0] ps;
    longint      wrap_edge;
    int          v;

    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_phase", phase_step_out, 0);
    check("reset_period", period_out, 0);
    check("reset_locked", locked, 0);
    check("reset_overrun", overrun, 0);
    check("reset_rv", result_valid, 0);

    // Generator at phase step 0x0100_0000: period 256.
    ph = 0;
    for (int i = 0; i < 1300; i++) begin
      drive(1'b1, ph[31:16]);
      ph = ph + 32'h0100_0000;
    end
    drive(1'b0, ph[31:16]);
    @(negedge clk);
    check("gen256_phase", phase_step_out, 32'h0100_0000);
    check("gen256_period", period_out, 256);
    check("gen256_locked", locked, 1);

    // Random generators with gaps in sample_valid.
    for (int g = 0; g < 4; g++) begin
      ps = $urandom_range(107374182, 2147483);
      ph = $urandom;
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(1'b1, ph[31:16]);
          ph = ph + ps;
        end else begin
          drive(1'b0, 16'($urandom));
        end
      end
    end

    // Period 1000 ramp; latency of the launching wrap.
    do_reset(2);
    wrap_edge = 0;
    for (int i = 0; i <= 3000; i++) begin
      v = -32768 + (i % 1000) * 65;
      drive(1'b1, 16'(v));
      if (i == 2000) wrap_edge = cyc + 1;
      if (i == 2100) begin
        check("p1000_latency", 64'(last_rv_edge - wrap_edge), LAT);
        check("p1000_phase", phase_step_out, 32'd4294967);
        check("p1000_period", period_out, 1000);
      end
    end

    // Glitch of -20000 mid-ramp must not register as a wrap.
    ramp(500, 131, 2000, 250);
    @(negedge clk);
    check("glitch_period", period_out, 500);
    check("glitch_phase", phase_step_out, 32'd8589934);

    // Constant input: counter saturates and lock drops.
    for (int i = 0; i < MAXC + 5; i++) drive(1'b1, 16'd1234);
    @(negedge clk);
    check("timeout_locked", locked, 0);

    // Period 10 is shorter than the divide: overrun.
    ramp(10, 6553, 300, -1);
    @(negedge clk);
    check("p10_overrun", overrun, 1);
    check("p10_phase", phase_step_out, 32'd429496729);

    // Reset 15 cycles into a divide, then relock.
    do_reset(2);
    wrap_edge = 0;
    for (int i = 0; i <= 215; i++) begin
      v = -32768 + (i % 100) * 655;
      drive(1'b1, 16'(v));
      if (i == 200) wrap_edge = cyc + 1;
      if (i == 215) rst = 1;
    end
    @(negedge clk);
    rst = 0;
    sample_valid = 0;
    check("midrst_phase", phase_step_out, 0);
    check("midrst_period", period_out, 0);
    check("midrst_locked", locked, 0);
    repeat (40) @(negedge clk);
    check("midrst_no_result", 64'(last_rv_edge > wrap_edge), 0);
    ramp(100, 655, 400, -1);
    @(negedge clk);
    check("relock_locked", locked, 1);
    check("relock_period", period_out, 100);
    check("relock_phase", phase_step_out, 32'd42949672);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
